// File: rtl/countdown_timer_ctrl_if.sv
// Bus between the countdown timer controller and its neighbours:
// request side (Start, Stop, Period), counter feedback (Q) and control outputs.
// Ports: Start/Stop/Period/Q into the controller; R/L/E/Done/Busy out of it.
interface countdown_timer_ctrl_if #(
   parameter int n = 8
);
   logic         Start;
   logic         Stop;
   logic [n-1:0] Period;
   logic [n-1:0] Q;
   logic [n-1:0] R;
   logic         L;
   logic         E;
   logic         Done;
   logic         Busy;

   modport master (
      output Start, Stop, Period, Q,
      input  R, L, E, Done, Busy
   );

   modport slave (
      input  Start, Stop, Period, Q,
      output R, L, E, Done, Busy
   );
endinterface

// File: rtl/countdown_timer_ctrl.sv
// Countdown timer controller: drives load value/strobe and count enable of a
// loadable down counter, runs a Period*DIV cycle interval and pulses Done.
// Ports: Clock, Resetn (sync, active low), bus (slave side of the timer bus).
// Optional auto-reload in DONE: define COUNTDOWN_TIMER_CTRL_AUTORELOAD_EN.
module countdown_timer_ctrl #(
   parameter int n   = 8,
   parameter int DIV = 4
) (
   input logic                   Clock,
   input logic                   Resetn,
   countdown_timer_ctrl_if.slave bus
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t        state;
   state_t        next;
   logic [PW-1:0] pre;
   logic [n-1:0]  r_q;
   logic          tick;
   logic          q_zero;
   logic          start_ok;

   assign tick     = (pre == PMAX);
   assign q_zero   = (bus.Q == '0);
   assign start_ok = bus.Start & (bus.Period != '0);

   // State, prescaler and captured period.
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state <= IDLE;
         pre   <= '0;
         r_q   <= '0;
      end else begin
         state <= next;
         if (state == IDLE && start_ok)
            r_q <= bus.Period;
`ifdef COUNTDOWN_TIMER_CTRL_AUTORELOAD_EN
         if (state == DONE)
            r_q <= bus.Period;
`endif
         // Prescaler only runs in RUN; it is held at 0 elsewhere, so it
         // starts from 0 on the first RUN cycle after LOAD.
         if (state == RUN)
            pre <= tick ? '0 : pre + PW'(1);
         else
            pre <= '0;
      end
   end

   // Next state; Stop beats the terminal-count detection.
   always_comb begin
      next = state;
      case (state)
         IDLE: begin
            if (start_ok)
               next = LOAD;
         end
         LOAD: begin
            next = bus.Stop ? IDLE : RUN;
         end
         RUN: begin
            if (bus.Stop)
               next = IDLE;
            else if (q_zero)
               next = DONE;
         end
         DONE: begin
`ifdef COUNTDOWN_TIMER_CTRL_AUTORELOAD_EN
            if (!bus.Stop && bus.Period != '0)
               next = LOAD;
            else
               next = IDLE;
`else
            next = IDLE;
`endif
         end
         default: next = IDLE;
      endcase
   end

   // Moore outputs; E is gated by Q so the counter never wraps below 0.
   always_comb begin
      bus.R    = r_q;
      bus.L    = 1'b0;
      bus.E    = 1'b0;
      bus.Done = 1'b0;
      bus.Busy = (state != IDLE);
      case (state)
         LOAD:    bus.L    = 1'b1;
         RUN:     bus.E    = tick & ~q_zero;
         DONE:    bus.Done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: doc/countdown_timer_ctrl.md
# countdown_timer_ctrl

Control stage that sits directly upstream of the loadable n-bit down counter and drives its load value, load strobe and count enable. It runs a one-shot (or, optionally, auto-reloading) timed interval of `Period × DIV` clock cycles. It watches the counter's `Q` for the terminal zero, then raises a one-cycle `Done`. All control outputs are Moore-decoded from state and the prescaler, so the counter sees clean, glitch-free strobes.

## Interface
- `n`, default 8: counter width; must match the downstream counter.
- `DIV`, default 4: prescale ratio, ≥1. The counter is decremented once every `DIV` clocks while running.
- `Clock`  in  1: single clock, rising edge.
- `Resetn`  in  1: synchronous active-low reset, sampled on the rising edge of `Clock`. Resets the controller only; the counter is reset by its own `Resetn` wiring.
- `Start`  in  1: request to begin an interval. Sampled only in IDLE.
- `Stop`  in  1: abort. Highest priority in every non-IDLE state.
- `Period`  in  n: interval length in prescaled ticks. Sampled on the accepting `Start` edge and again in DONE when auto-reload is enabled.
- `Q`  in  n: present count, fed back from the downstream counter.
- `R`  out  n: load value to the counter. Registered copy of the captured `Period`.
- `L`  out  1: counter load strobe.
- `E`  out  1: counter count enable.
- `Done`  out  1: one-cycle pulse at the end of each interval.
- `Busy`  out  1: high whenever state ≠ IDLE.

## Operation
- States: IDLE, LOAD, RUN, DONE. Binary encoding; the `default` case goes to IDLE.
- IDLE: `L`=`E`=`Done`=0.
  - `Start`=1 and `Period`≠0: capture `Period` into `R`, then go to LOAD.
  - `Start` with `Period`=0 is ignored; the block stays in IDLE.
- LOAD: `L`=1 for exactly one cycle and the prescaler clears to 0. Next state is RUN.
- RUN: the prescaler counts 0..DIV-1 and wraps.
  - `E` = (prescaler == DIV-1) & (`Q` ≠ 0).
  - `Q` == 0 moves to DONE. `E` is never asserted when `Q`=0, so the counter never wraps to 2^n-1.
- DONE: `Done`=1 for one cycle.
  - Without auto-reload: go to IDLE.
  - With auto-reload: see Configuration.
- `Stop`=1 in LOAD, RUN or DONE goes to IDLE on the next edge. No `Done` pulse is produced unless the block is already in DONE. `Stop` beats the `Q`==0 detection.
- `Start` while `Busy` is ignored. `Start` and `Stop` together in IDLE are treated as `Start`, because `Stop` has no effect in IDLE.
- Prescaler width is clog2(DIV), minimum 1 bit. Prescaler compare is done at full width. `R` holds its value outside LOAD.

## Timing
- Reset values: state IDLE, prescaler 0, `R`=0, `L`=0, `E`=0, `Done`=0, `Busy`=0.
- Reset asserted mid-interval returns all outputs to their reset values on that edge. The counter's `Q` is not cleared by this block.
- Cycle numbering uses edge 0 as the edge that samples an accepted `Start`:
  - LOAD occupies the cycle after edge 0, with `L`=1.
  - Edge 1: the counter loads `Period`, RUN begins, and `Busy`=1.
  - The j-th `E` pulse is high in the cycle before edge 1+j·DIV.
  - `Q` reaches 0 after edge 1+Period·DIV.
  - DONE is entered at edge 2+Period·DIV, so `Done` is high in the cycle following that edge.
  - Start-to-`Done` latency is therefore Period·DIV + 2 edges.
- With DIV=1, `E` is high every RUN cycle in which `Q`≠0.
- `Busy` falls on the edge leaving DONE (one-shot) or the edge after `Stop` is sampled.

## Configuration
- Macro: `COUNTDOWN_TIMER_CTRL_AUTORELOAD_EN`.
- Defined:
  - DONE re-samples `Period` into `R`. If the new value is ≠0 and `Stop`=0, the next state is LOAD; otherwise it is IDLE.
  - Consecutive `Done` pulses are Period·DIV + 3 cycles apart.
- Undefined: DONE always goes to IDLE (one-shot). `Period` is sampled only in IDLE.

## Test plan
- Reset: hold `Resetn`=0 for 3 edges with `Start`=1 → `Busy`, `L`, `E` and `Done` all stay 0. Release → controller is in IDLE.
- One-shot with n=8, DIV=4, `Period`=3, `Start` pulse → `L` high for 1 cycle, exactly 3 `E` pulses spaced 4 cycles apart, `Q` goes 3,2,1,0, `Done` pulses once 14 edges after `Start`, then `Busy`=0.
- DIV=1, `Period`=1 → one `E` pulse, `Done` 3 edges after `Start`, and `Q` never reads 0xFF.
- `Stop` asserted 5 cycles into RUN with `Period`=10 → IDLE on the next edge, no `Done`, no further `E`.
- `Start` with `Period`=0 → no state change. A second `Start` issued while `Busy` → ignored, and the first interval completes normally.
- With `COUNTDOWN_TIMER_CTRL_AUTORELOAD_EN`, `Period`=2, DIV=2:
  - `Done` pulses repeat every 7 cycles.
  - Changing `Period` to 0 before the next DONE → one final `Done`, then IDLE.
